instr_mem_loader: RTL
=====================

# instr_mem_loader

Boot-time instruction encoder and loader for the single-cycle CPU. It accepts decoded instruction fields (opcode, register numbers, shift amount, immediate, jump target) over a valid/ready handshake and packs them into 32-bit instruction words. It writes each word big-endian, one byte per cycle, into the byte-wide instruction memory, and appends a halt word when the stream ends. While loading, it holds the CPU's PC (`cpu_hold` gates PCWre) and releases it when the program image is complete.

## Interface
- `ADDR_W`, 8: instruction-memory byte-address width; capacity is 2^ADDR_W/4 words.
- `BASE`, 0: byte address of the first word; must be a multiple of 4.
- `CLK` in 1: single clock; everything is rising-edge.
- `Reset` in 1: synchronous, active-high; dominates all other inputs.
- `in_valid` in 1: field bundle valid.
- `in_ready` out 1: loader can accept a bundle; forced to 0 while `Reset` is high.
- `in_op` in 6: opcode.
- `in_rs`, `in_rt`, `in_rd`, `in_sa` in 5 each: register fields and shift amount.
- `in_imm` in 16: I-type immediate.
- `in_addr` in 26: J-type word target.
- `in_last` in 1: this bundle ends the program.
- `mem_we` out 1: byte write strobe to instruction memory.
- `mem_addr` out ADDR_W: byte address.
- `mem_wbyte` out 8: byte data.
- `cpu_hold` out 1: 1 = CPU PC frozen.
- `done` out 1: image complete; sticky until `Reset`.
- `err_op` out 1: sticky; an illegal opcode was received.
- `err_full` out 1: sticky; the image was truncated because memory was full.

## Operation
- **Transfer:** a bundle is transferred on any rising edge where `in_valid && in_ready`.
- **Encoding** (bit 31 is the MSB):
  - R-type (add 000000, sub 000010, and 010001, or 010010, slt 011001): op|rs|rt|rd|00000|000000.
  - sll 011000: op|00000|rt|rd|sa|000000. `in_rs` is ignored.
  - I-type (addi 000001, subi 000011, ori 010000, slti 011011, sw 100110, lw 100111, beq 110000, bne 110001): op|rs|rt|imm.
  - j 111000: op|addr[25:0].
  - halt 111111: op|26'b0 = 0xFC000000.
- **Illegal opcode** (any other value): the bundle is accepted and dropped. `err_op` is set, nothing is written, the pointer is unchanged, and the loader stays in IDLE. If `in_last` was set on the illegal bundle, the loader proceeds directly to the halt write.
- **FSM states:** IDLE → WR (4 byte beats) → IDLE, or → HALT (4 beats) → DONE.
  - After WR: go to HALT if `in_last` is set and the opcode is not halt. Go to DONE if `in_last` is set and the opcode is halt (no extra halt is appended). Otherwise return to IDLE.
- **Byte order:** beat k (0..3) drives `mem_wbyte` = word[31-8k -: 8] at `mem_addr` = ptr+k. The pointer advances by 4 after beat 3.
- **Full:** the last word slot is reserved for halt. If a non-halt, non-last bundle is accepted while ptr is at the last slot, the bundle is discarded, `err_full` is set, and the loader goes to HALT at that slot, then DONE.
- **DONE:** `in_ready` = 0, `cpu_hold` = 0, `done` = 1. The loader stays in DONE until `Reset`.
- **Reset** (including mid-write): state returns to IDLE, ptr = BASE, all outputs take their reset values on the next edge. Bytes already written are left in memory.

## Timing
- **Reset values:** `mem_we` 0, `mem_addr` BASE, `mem_wbyte` 0, `cpu_hold` 1, `done` 0, `err_op` 0, `err_full` 0. `in_ready` becomes 1 on the first cycle after `Reset` falls.
- **Write latency:** for a bundle accepted at edge T, `mem_we` is high for the cycles following edges T+1 through T+4. `in_ready` is low for those 4 cycles and high again after edge T+4. Throughput is 1 word per 5 cycles.
- **Halt write:** occupies the 4 cycles immediately after the last data beat.
- **Release:** `done` and `cpu_hold` change in the cycle after the final halt beat.
- All outputs are registered.

## Structure
- **Shared package `isa_pkg`:**
  - Opcode localparams, named exactly as the CPU's decoder uses them.
  - Field bit positions.
  - `HALT_WORD`.
  - State enum.
- **Sub-module `instr_word_pack`:** combinational fields→word packer with a `legal` flag. It is reusable by the testbench's reference model.

## Test plan
- **add:** add (op 0, rs 1, rt 2, rd 3), then idle → bytes 00,22,18,00 at addresses 0..3. `in_ready` is low for exactly 4 cycles and `done` stays 0.
- **addi with in_last:** addi (rs 0, rt 1, imm 8) with `in_last` → 0x04010008 at 0..3, then FC,00,00,00 at 4..7. `done` = 1 and `cpu_hold` = 0 in the next cycle.
- **sll and j:** sll (rs 7, rt 1, rd 2, sa 2) → 0x60011080, proving rs is ignored. j with addr 0x10 → 0xE0000010.
- **Illegal opcode:** op 101010 → no `mem_we` and `err_op` = 1. The next legal word lands at address 0.
- **Full:** with ADDR_W = 4, send 4 non-last adds → words written at 0, 4, 8. The fourth is dropped, `err_full` = 1, halt is written at 12, and `done` = 1.
- **Reset mid-write:** assert `Reset` during beat 1 of a write → `mem_we` = 0 the next cycle, ptr = 0, `cpu_hold` = 1. The following bundle is written starting at address 0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the single-cycle CPU and its boot loader:
// opcodes, instruction field positions, the halt word and loader states.
package isa_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b011001;
    localparam logic [5:0] OP_SLTI = 6'b011011;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam int OP_LSB   = 26;
    localparam int RS_LSB   = 21;
    localparam int RT_LSB   = 16;
    localparam int RD_LSB   = 11;
    localparam int SA_LSB   = 6;
    localparam int IMM_LSB  = 0;
    localparam int ADDR_LSB = 0;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_HALT,
        S_DONE
    } state_t;

    // Big-endian byte k of a word: k = 0 is bits 31:24.
    function automatic logic [7:0] word_byte(input logic [31:0] w,
                                             input logic [1:0]  k);
        logic [31:0] s;
        s = w << {k, 3'b000};
        return s[31:24];
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Field-bundle handshake between the boot source and the loader.
// The source drives valid and fields; the loader drives ready.
interface instr_mem_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_sa;
    logic [15:0] in_imm;
    logic [25:0] in_addr;
    logic        in_last;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd,
        output in_sa, in_imm, in_addr, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd,
        input  in_sa, in_imm, in_addr, in_last,
        output in_ready
    );

endinterface

// File: rtl/instr_word_pack.sv
// Combinational packer from decoded fields to a 32-bit instruction word.
// legal is low (and word is zero) for opcodes the CPU does not implement.
module instr_word_pack
    import isa_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    output logic [31:0] word,
    output logic        legal
);

    // Place each field for the instruction format selected by the opcode.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                word[OP_LSB +: 6] = op;
                word[RS_LSB +: 5] = rs;
                word[RT_LSB +: 5] = rt;
                word[RD_LSB +: 5] = rd;
            end
            OP_SLL: begin
                word[OP_LSB +: 6] = op;
                word[RT_LSB +: 5] = rt;
                word[RD_LSB +: 5] = rd;
                word[SA_LSB +: 5] = sa;
            end
            OP_ADDI, OP_SUBI, OP_ORI, OP_SLTI,
            OP_SW, OP_LW, OP_BEQ, OP_BNE: begin
                word[OP_LSB +: 6]    = op;
                word[RS_LSB +: 5]    = rs;
                word[RT_LSB +: 5]    = rt;
                word[IMM_LSB +: 16]  = imm;
            end
            OP_J: begin
                word[OP_LSB +: 6]    = op;
                word[ADDR_LSB +: 26] = addr;
            end
            OP_HALT: begin
                word = HALT_WORD;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time loader: packs field bundles into words, writes them big-endian
// a byte per cycle into instruction memory, appends halt, then frees the CPU.
module instr_mem_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    instr_mem_loader_if.slave bundle,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wbyte,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_op,
    output logic              err_full
);

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_SLOT = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t            state;
    state_t            nxt_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] nxt_ptr;
    logic [1:0]        cnt;
    logic [1:0]        nxt_cnt;
    logic [31:0]       word_q;
    logic [31:0]       nxt_word;
    logic              last_q;
    logic              nxt_last;
    logic              halt_q;
    logic              nxt_halt;
    logic              nxt_err_op;
    logic              nxt_err_full;
    logic              rdy_q;
    logic              wr_en;
    logic [ADDR_W-1:0] nxt_addr;
    logic [7:0]        nxt_wbyte;

    logic [31:0]       pack_word;
    logic              legal;
    logic              accept;
    logic              at_last;
    logic              is_halt;

    instr_word_pack u_pack (
        .op    (bundle.in_op),
        .rs    (bundle.in_rs),
        .rt    (bundle.in_rt),
        .rd    (bundle.in_rd),
        .sa    (bundle.in_sa),
        .imm   (bundle.in_imm),
        .addr  (bundle.in_addr),
        .word  (pack_word),
        .legal (legal)
    );

    assign bundle.in_ready = rdy_q && !Reset;
    assign accept  = bundle.in_valid && rdy_q;
    assign at_last = (ptr == LAST_SLOT);
    assign is_halt = (bundle.in_op == OP_HALT);

    // Next-state, pointer, latched word and next registered outputs.
    always_comb begin
        nxt_state    = state;
        nxt_ptr      = ptr;
        nxt_cnt      = cnt;
        nxt_word     = word_q;
        nxt_last     = last_q;
        nxt_halt     = halt_q;
        nxt_err_op   = err_op;
        nxt_err_full = err_full;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_cnt = 2'd0;
                    if (!legal) begin
                        nxt_err_op = 1'b1;
                        if (bundle.in_last) begin
                            nxt_state = S_HALT;
                        end
                    end else if (at_last && !is_halt) begin
                        // Last slot is kept for halt; drop the word.
                        nxt_err_full = 1'b1;
                        nxt_state    = S_HALT;
                    end else begin
                        // A halt landing in the last slot ends the image.
                        nxt_state = S_WR;
                        nxt_word  = pack_word;
                        nxt_last  = bundle.in_last || at_last;
                        nxt_halt  = is_halt;
                    end
                end
            end
            S_WR: begin
                nxt_cnt = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    nxt_ptr = ptr + WORD_STEP;
                    if (last_q && halt_q) begin
                        nxt_state = S_DONE;
                    end else if (last_q) begin
                        nxt_state = S_HALT;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                nxt_cnt = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    nxt_state = S_DONE;
                end
            end
            S_DONE: begin
                nxt_state = S_DONE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        wr_en     = (state == S_WR) || (state == S_HALT);
        nxt_addr  = ptr + {{(ADDR_W-2){1'b0}}, cnt};
        nxt_wbyte = 8'h00;
        if (state == S_HALT) begin
            nxt_wbyte = word_byte(HALT_WORD, cnt);
        end else if (state == S_WR) begin
            nxt_wbyte = word_byte(word_q, cnt);
        end
    end

    // State, datapath and output registers; Reset overrides everything.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= S_IDLE;
            ptr       <= BASE_A;
            cnt       <= 2'd0;
            word_q    <= '0;
            last_q    <= 1'b0;
            halt_q    <= 1'b0;
            rdy_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_A;
            mem_wbyte <= 8'h00;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err_op    <= 1'b0;
            err_full  <= 1'b0;
        end else begin
            state     <= nxt_state;
            ptr       <= nxt_ptr;
            cnt       <= nxt_cnt;
            word_q    <= nxt_word;
            last_q    <= nxt_last;
            halt_q    <= nxt_halt;
            rdy_q     <= (nxt_state == S_IDLE);
            mem_we    <= wr_en;
            mem_addr  <= nxt_addr;
            mem_wbyte <= nxt_wbyte;
            cpu_hold  <= (state != S_DONE);
            done      <= (state == S_DONE);
            err_op    <= nxt_err_op;
            err_full  <= nxt_err_full;
        end
    end

endmodule
